// File: rtl/alu_arbiter.sv
// alu_arbiter: grants one of two requesters access to a shared combinational ALU
// and returns its result. Optional opcode screening: define ALU_ARBITER_OPCHECK_EN.
module alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    input  logic             resp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
`ifdef ALU_ARBITER_OPCHECK_EN
    logic             bad_op_q, bad_op_d;
    logic             resp_err_q, resp_err_d;

    function automatic logic op_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b1101};
    endfunction
`endif

    logic             grant0, grant1, accept, sel;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;

    // prio only breaks ties; a lone valid requester is always granted.
    always_comb begin
        grant0 = (state_q == IDLE) && req0_valid && (!req1_valid || !prio_q);
        grant1 = (state_q == IDLE) && req1_valid && (!req0_valid ||  prio_q);
        accept = grant0 || grant1;
        sel    = grant1;
        sel_op = sel ? req1_op : req0_op;
        sel_a  = sel ? req1_a  : req0_a;
        sel_b  = sel ? req1_b  : req0_b;
    end

    // Ready is combinational from valid, so it is masked while reset is held.
    assign req0_ready = grant0 && reset_n;
    assign req1_ready = grant1 && reset_n;

    always_comb begin
        // NOTE: every _d starts from its _q, so no branch can leave a latch behind.
        state_d      = state_q;
        prio_d       = prio_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
`ifdef ALU_ARBITER_OPCHECK_EN
        bad_op_d     = bad_op_q;
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = EXEC;
                    resp_id_d = sel;
`ifdef ALU_ARBITER_OPCHECK_EN
                    bad_op_d = !op_legal(sel_op);
                    if (op_legal(sel_op)) begin
                        alu_op_d = sel_op;
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                    end
`else
                    alu_op_d = sel_op;
                    alu_a_d  = sel_a;
                    alu_b_d  = sel_b;
`endif
                end
            end
            EXEC: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
`ifdef ALU_ARBITER_OPCHECK_EN
                resp_data_d  = bad_op_q ? '0 : alu_result;
                resp_err_d   = bad_op_q;
`else
                resp_data_d  = alu_result;
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    prio_d       = !resp_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            alu_op_q     <= 4'b0000;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
`ifdef ALU_ARBITER_OPCHECK_EN
            bad_op_q     <= 1'b0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
`ifdef ALU_ARBITER_OPCHECK_EN
            bad_op_q     <= bad_op_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
`ifdef ALU_ARBITER_OPCHECK_EN
    assign resp_err   = resp_err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule
